// File: rtl/neural_soc_key_pkg.sv
// neural_soc_key_pkg: shared constants and channel FSM state type for the key debouncer.
//   KEY_COUNT               - number of push-button channels
//   DEFAULT_DEBOUNCE_CYCLES - stable samples needed to accept a change (10 ms at 50 MHz)
//   DEFAULT_SYNC_STAGES     - depth of the input synchronizer
//   key_state_t             - per-channel FSM state
package neural_soc_key_pkg;

    localparam int KEY_COUNT               = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } key_state_t;

endpackage

// File: rtl/neural_soc_key_debounce_ch.sv
// neural_soc_key_debounce_ch: one key channel - synchronizer, stability counter, FSM, edge pulses.
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   key_raw     - asynchronous active-low button pin
//   key_out     - debounced level, same polarity as key_raw
//   key_press   - one-cycle pulse when key_out goes 1->0
//   key_release - one-cycle pulse when key_out goes 0->1
module neural_soc_key_debounce_ch
    import neural_soc_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    key_state_t             state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   out_nx, press_nx, release_nx;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= '1;
            state       <= ST_STABLE;
            cnt         <= '0;
            key_out     <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], key_raw};
            state       <= state_nx;
            cnt         <= cnt_nx;
            key_out     <= out_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
        end
    end

    // Any sample equal to key_out aborts a pending change; the level only
    // flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        out_nx     = key_out;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        if (s == key_out) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
        end else if (state == ST_STABLE) begin
            state_nx = ST_COUNT;
            cnt_nx   = CW'(1);
        end else if (cnt == CNT_LAST) begin
            state_nx   = ST_STABLE;
            cnt_nx     = '0;
            out_nx     = s;
            press_nx   = ~s;
            release_nx = s;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end

endmodule

// File: rtl/neural_soc_key_debounce.sv
// neural_soc_key_debounce: debounces the push-button bank with one independent channel per key.
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   key_raw     - asynchronous active-low button pins (1 = released)
//   key_out     - debounced levels, same polarity; feeds the key PIO in_port
//   key_press   - per-key one-cycle pulse on debounced 1->0
//   key_release - per-key one-cycle pulse on debounced 0->1
module neural_soc_key_debounce
    import neural_soc_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [KEY_COUNT-1:0] key_raw,
    output logic [KEY_COUNT-1:0] key_out,
    output logic [KEY_COUNT-1:0] key_press,
    output logic [KEY_COUNT-1:0] key_release
);

    for (genvar i = 0; i < KEY_COUNT; i++) begin : g_ch
        neural_soc_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_out     (key_out[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_neural_soc_key_debounce.sv
// tb_neural_soc_key_debounce: directed and randomized checks of the key debouncer.
module tb_neural_soc_key_debounce;

    localparam int DEB = 8;
    localparam int SYN = 2;
    localparam int CHG = SYN + DEB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] key_out, key_press, key_release;

    int total = 0;
    int passed = 0;

    logic [3:0] m_pipe [SYN];
    logic [3:0] m_out, m_press, m_release;
    int         m_run [4];

    neural_soc_key_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Reference: a key's level flips once DEB consecutive synchronized samples disagree with it.
    task automatic model_reset();
        for (int j = 0; j < SYN; j++) m_pipe[j] = 4'hF;
        m_out = 4'hF;
        m_press = 4'h0;
        m_release = 4'h0;
        for (int k = 0; k < 4; k++) m_run[k] = 0;
    endtask

    task automatic model_tick();
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                m_press[k] = 1'b0;
                m_release[k] = 1'b0;
                if (m_pipe[SYN-1][k] == m_out[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DEB) begin
                        m_out[k] = m_pipe[SYN-1][k];
                        m_press[k] = ~m_out[k];
                        m_release[k] = m_out[k];
                        m_run[k] = 0;
                    end
                end
            end
            for (int j = SYN - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = key_raw;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic settle();
        for (int k = 0; k < CHG + 3; k++) step();
    endtask

    task automatic test_reset();
        key_raw = 4'hF;
        reset_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) step();
        total++; if (key_out !== 4'hF) $display("FAIL reset_out: got %h want f", key_out); else passed++;
        total++; if (key_press !== 4'h0) $display("FAIL reset_press: got %b want 0000", key_press); else passed++;
        total++; if (key_release !== 4'h0) $display("FAIL reset_release: got %b want 0000", key_release); else passed++;
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            total++; if (key_out !== 4'hF) $display("FAIL post_reset_out k=%0d: got %h want f", k, key_out); else passed++;
            total++; if ((key_press | key_release) !== 4'h0) $display("FAIL post_reset_pulse k=%0d: got %b/%b want 0", k, key_press, key_release); else passed++;
        end
    endtask

    task automatic test_single_press();
        key_raw[0] = 1'b0;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_out[0] !== (k >= CHG ? 1'b0 : 1'b1)) $display("FAIL press_level k=%0d: got %b want %b", k, key_out[0], k < CHG); else passed++;
            total++; if (key_press !== (k == CHG ? 4'b0001 : 4'b0000)) $display("FAIL press_pulse k=%0d: got %b", k, key_press); else passed++;
        end
        key_raw[0] = 1'b1;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_out[0] !== (k >= CHG ? 1'b1 : 1'b0)) $display("FAIL release_level k=%0d: got %b want %b", k, key_out[0], k >= CHG); else passed++;
            total++; if (key_release !== (k == CHG ? 4'b0001 : 4'b0000)) $display("FAIL release_pulse k=%0d: got %b", k, key_release); else passed++;
            total++; if (key_press !== 4'b0000) $display("FAIL release_nopress k=%0d: got %b want 0000", k, key_press); else passed++;
        end
    endtask

    task automatic test_bounce();
        key_raw[1] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        key_raw[1] = 1'b1;
        step();
        key_raw[1] = 1'b0;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_out[1] !== (k >= CHG ? 1'b0 : 1'b1)) $display("FAIL bounce_level k=%0d: got %b want %b", k, key_out[1], k < CHG); else passed++;
            total++; if (key_press !== (k == CHG ? 4'b0010 : 4'b0000)) $display("FAIL bounce_pulse k=%0d: got %b", k, key_press); else passed++;
        end
        key_raw[1] = 1'b1;
        settle();
    endtask

    task automatic test_short_pulse();
        key_raw[2] = 1'b0;
        for (int k = 0; k < DEB - 1; k++) step();
        key_raw[2] = 1'b1;
        for (int k = 1; k <= CHG + 4; k++) begin
            step();
            total++; if (key_out !== 4'hF) $display("FAIL short_level k=%0d: got %h want f", k, key_out); else passed++;
            total++; if ((key_press | key_release) !== 4'h0) $display("FAIL short_pulse k=%0d: got %b/%b want 0", k, key_press, key_release); else passed++;
        end
        key_raw[2] = 1'b0;
        for (int k = 0; k < DEB; k++) begin
            step();
            total++; if (key_out[2] !== 1'b1) $display("FAIL exact_early k=%0d: got %b want 1", k, key_out[2]); else passed++;
        end
        key_raw[2] = 1'b1;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_out[2] !== ((k < 2 || k >= CHG) ? 1'b1 : 1'b0)) $display("FAIL exact_level k=%0d: got %b", k, key_out[2]); else passed++;
            total++; if (key_press !== (k == 2 ? 4'b0100 : 4'b0000)) $display("FAIL exact_press k=%0d: got %b", k, key_press); else passed++;
            total++; if (key_release !== (k == CHG ? 4'b0100 : 4'b0000)) $display("FAIL exact_release k=%0d: got %b", k, key_release); else passed++;
        end
    endtask

    task automatic test_simultaneous();
        key_raw[3:2] = 2'b00;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_out !== (k >= CHG ? 4'b0011 : 4'b1111)) $display("FAIL simul_level k=%0d: got %b", k, key_out); else passed++;
            total++; if (key_press !== (k == CHG ? 4'b1100 : 4'b0000)) $display("FAIL simul_press k=%0d: got %b", k, key_press); else passed++;
        end
        key_raw[3:2] = 2'b11;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_release !== (k == CHG ? 4'b1100 : 4'b0000)) $display("FAIL simul_release k=%0d: got %b", k, key_release); else passed++;
        end
    endtask

    task automatic test_reset_mid_count();
        key_raw[0] = 1'b0;
        for (int k = 0; k < 7; k++) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (key_out !== 4'hF) $display("FAIL midrst_out: got %h want f", key_out); else passed++;
        step();
        step();
        total++; if (key_out !== 4'hF) $display("FAIL midrst_hold: got %h want f", key_out); else passed++;
        reset_n = 1'b1;
        for (int k = 1; k <= CHG + 2; k++) begin
            step();
            total++; if (key_out[0] !== (k >= CHG ? 1'b0 : 1'b1)) $display("FAIL midrst_level k=%0d: got %b want %b", k, key_out[0], k < CHG); else passed++;
            total++; if (key_press !== (k == CHG ? 4'b0001 : 4'b0000)) $display("FAIL midrst_pulse k=%0d: got %b", k, key_press); else passed++;
        end
        key_raw[0] = 1'b1;
        settle();
    endtask

    task automatic test_random();
        int hold [4];
        for (int k = 0; k < 4; k++) hold[k] = $urandom_range(1, 12);
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 4; k++) begin
                hold[k]--;
                if (hold[k] == 0) begin
                    key_raw[k] = ~key_raw[k];
                    hold[k] = $urandom_range(1, 14);
                end
            end
            step();
            total++; if (key_out !== m_out) $display("FAIL rand_out c=%0d: got %b want %b", c, key_out, m_out); else passed++;
            total++; if (key_press !== m_press) $display("FAIL rand_press c=%0d: got %b want %b", c, key_press, m_press); else passed++;
            total++; if (key_release !== m_release) $display("FAIL rand_release c=%0d: got %b want %b", c, key_release, m_release); else passed++;
            total++; if ((key_press & key_release) !== 4'h0) $display("FAIL rand_both c=%0d: got %b", c, key_press & key_release); else passed++;
        end
        key_raw = 4'hF;
        settle();
        total++; if (key_out !== 4'hF) $display("FAIL rand_final: got %h want f", key_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_short_pulse();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
